// File: rtl/asc_pkg.sv
// Shared encodings and floor-mask helpers for the single-car elevator controller.
package asc_pkg;

   localparam int N_PISOS = 4;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MOVING = 2'd1,
      DOORS  = 2'd2
   } asc_state_t;

   typedef logic [N_PISOS-1:0] pisos_t;

   function automatic pisos_t onehot(input logic [1:0] p);
      return pisos_t'(1) << p;
   endfunction

   // Floors strictly above p when up=1, strictly below p when up=0.
   function automatic pisos_t ahead_mask(input logic [1:0] p, input logic up);
      pisos_t below;
      below = onehot(p) - pisos_t'(1);
      return up ? ~(below | onehot(p)) : below;
   endfunction

endpackage

// File: rtl/asc_if.sv
// Call inputs and car-state outputs of the elevator controller.
interface asc_if;
   logic [asc_pkg::N_PISOS-1:0] llamada;
   logic [1:0]                  piso;
   logic [1:0]                  direccion;
   logic                        puertas_abiertas;
   logic [asc_pkg::N_PISOS-1:0] pendientes;

   modport master (output llamada, input piso, direccion, puertas_abiertas, pendientes);
   modport slave  (input llamada, output piso, direccion, puertas_abiertas, pendientes);
endinterface

// File: rtl/asc_timer.sv
// Loadable down-counter shared by travel and door timing; done_o while the count is zero.
module asc_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/controlador_ascensor.sv
// Single-car 4-floor SCAN elevator controller (IDLE / MOVING / DOORS).
// Optional ASC_DOOR_EXTEND_EN: a call for the current floor while doors are open restarts the door time.
module controlador_ascensor
   import asc_pkg::*;
#(
   parameter int TICKS_MOVE = 50_000_000,
   parameter int TICKS_DOOR = 100_000_000
) (
   input logic clk,
   input logic rst_n,
   asc_if.slave bus
);

   localparam int TICKS_MAX = (TICKS_MOVE > TICKS_DOOR) ? TICKS_MOVE : TICKS_DOOR;
   localparam int TW        = (TICKS_MAX > 1) ? $clog2(TICKS_MAX) : 1;
   localparam logic [TW-1:0] LOAD_MOVE = TW'(TICKS_MOVE - 1);
   localparam logic [TW-1:0] LOAD_DOOR = TW'(TICKS_DOOR - 1);

   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_MOVING = MOVING;
   localparam logic [1:0] ST_DOORS  = DOORS;

   logic [1:0]    state_q, state_d;
   logic [1:0]    piso_q, piso_d;
   logic [1:0]    dir_q, dir_d;
   logic          doors_q, doors_d;
   logic          scan_up_q, scan_up_d;
   pisos_t        pend_q, pend_d;

   pisos_t        pend_in;
   pisos_t        clr;
   logic [1:0]    piso_step;
   logic          tmr_load;
   logic [TW-1:0] tmr_val;
   logic          tmr_done;

   asc_timer #(.W(TW)) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .done_o    (tmr_done)
   );

   assign pend_in   = pend_q | bus.llamada;
   assign piso_step = scan_up_q ? piso_q + 2'd1 : piso_q - 2'd1;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      piso_d    = piso_q;
      dir_d     = dir_q;
      doors_d   = doors_q;
      scan_up_d = scan_up_q;
      clr       = '0;
      tmr_load  = 1'b0;
      tmr_val   = LOAD_MOVE;

      case (state_q)
         ST_IDLE: begin
            if (pend_q[piso_q]) begin
               state_d  = ST_DOORS;
               doors_d  = 1'b1;
               dir_d    = DIR_STOP;
               clr      = onehot(piso_q);
               tmr_load = 1'b1;
               tmr_val  = LOAD_DOOR;
            end else if ((pend_q & ahead_mask(piso_q, scan_up_q)) != '0) begin
               state_d  = ST_MOVING;
               dir_d    = scan_up_q ? DIR_UP : DIR_DOWN;
               tmr_load = 1'b1;
            end else if ((pend_q & ahead_mask(piso_q, !scan_up_q)) != '0) begin
               state_d   = ST_MOVING;
               scan_up_d = !scan_up_q;
               dir_d     = scan_up_q ? DIR_DOWN : DIR_UP;
               tmr_load  = 1'b1;
            end
         end

         ST_MOVING: begin
            if (tmr_done) begin
               piso_d = piso_step;
               // Arrival decisions see this edge's calls already latched.
               if (pend_in[piso_step]) begin
                  state_d  = ST_DOORS;
                  doors_d  = 1'b1;
                  dir_d    = DIR_STOP;
                  clr      = onehot(piso_step);
                  tmr_load = 1'b1;
                  tmr_val  = LOAD_DOOR;
               end else if ((pend_in & ahead_mask(piso_step, scan_up_q)) != '0) begin
                  tmr_load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  dir_d   = DIR_STOP;
               end
            end
         end

         ST_DOORS: begin
            clr = onehot(piso_q);
`ifdef ASC_DOOR_EXTEND_EN
            if (bus.llamada[piso_q]) begin
               tmr_load = 1'b1;
               tmr_val  = LOAD_DOOR;
            end else if (tmr_done) begin
               state_d = ST_IDLE;
               doors_d = 1'b0;
            end
`else
            if (tmr_done) begin
               state_d = ST_IDLE;
               doors_d = 1'b0;
            end
`endif
         end

         default: begin
            state_d = ST_IDLE;
            dir_d   = DIR_STOP;
            doors_d = 1'b0;
         end
      endcase

      pend_d = pend_in & ~clr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         piso_q    <= 2'd0;
         dir_q     <= DIR_STOP;
         doors_q   <= 1'b0;
         scan_up_q <= 1'b1;
         pend_q    <= '0;
      end else begin
         state_q   <= state_d;
         piso_q    <= piso_d;
         dir_q     <= dir_d;
         doors_q   <= doors_d;
         scan_up_q <= scan_up_d;
         pend_q    <= pend_d;
      end
   end

   assign bus.piso             = piso_q;
   assign bus.direccion        = dir_q;
   assign bus.puertas_abiertas = doors_q;
   assign bus.pendientes       = pend_q;

endmodule

// File: tb/tb_controlador_ascensor.sv
// Self-checking bench for controlador_ascensor: directed table, corner-case sequences, random vs model.
module tb_controlador_ascensor;

   localparam int TM = 4;
   localparam int TD = 3;
`ifdef ASC_DOOR_EXTEND_EN
   localparam bit EXTEND = 1'b1;
`else
   localparam bit EXTEND = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   asc_if io ();

   controlador_ascensor #(.TICKS_MOVE(TM), .TICKS_DOOR(TD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (io)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: position, heading (+1/-1), remaining travel and door cycles.
   int         m_floor, m_head, m_travel, m_door;
   logic [3:0] m_pend;

   int  stops[$];
   int  door_len[$];
   int  dirseq[$];
   bit  prev_doors;

   typedef struct {
      logic [3:0] l;
      logic [1:0] piso;
      logic [1:0] dir;
      logic       doors;
      logic [3:0] pend;
   } vec_t;
   vec_t tbl[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit any_beyond(input int f, input int h, input logic [3:0] p);
      for (int k = 0; k < 4; k++)
         if (p[k] && (k - f) * h > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      m_floor = 0; m_head = 1; m_travel = 0; m_door = 0; m_pend = 4'b0;
   endtask

   task automatic model_step(input logic [3:0] l);
      logic [3:0] old;
      logic [3:0] here;
      old  = m_pend;
      here = 4'b0001 << m_floor;
      if (m_door > 0) begin
         m_pend = m_pend | (l & ~here);
         if (EXTEND && l[m_floor]) m_door = TD;
         else m_door--;
      end else if (m_travel > 0) begin
         m_pend = m_pend | l;
         m_travel--;
         if (m_travel == 0) begin
            m_floor += m_head;
            if (m_pend[m_floor]) begin
               m_pend[m_floor] = 1'b0;
               m_door = TD;
            end else if (any_beyond(m_floor, m_head, m_pend)) begin
               m_travel = TM;
            end
         end
      end else begin
         m_pend = m_pend | l;
         if (old[m_floor]) begin
            m_pend[m_floor] = 1'b0;
            m_door = TD;
         end else if (any_beyond(m_floor, m_head, old)) begin
            m_travel = TM;
         end else if (any_beyond(m_floor, -m_head, old)) begin
            m_head = -m_head;
            m_travel = TM;
         end
      end
   endtask

   function automatic logic [8:0] model_vec();
      logic [1:0] d;
      d = (m_travel > 0) ? ((m_head > 0) ? 2'b01 : 2'b10) : 2'b00;
      return {2'(m_floor), d, (m_door > 0), m_pend};
   endfunction

   function automatic logic [8:0] dut_vec();
      return {io.piso, io.direccion, io.puertas_abiertas, io.pendientes};
   endfunction

   function automatic int code(input int q[$]);
      int c = 0;
      for (int i = 0; i < q.size() && i < 8; i++) c = c * 16 + q[i];
      return c;
   endfunction

   task automatic clear_log();
      stops.delete(); door_len.delete(); dirseq.delete();
   endtask

   // One clock: drive calls, advance the model on the edge, compare on the falling edge.
   task automatic cycle(input logic [3:0] l);
      io.llamada = l;
      @(posedge clk);
      model_step(l);
      @(negedge clk);
      check("model", dut_vec(), model_vec());
      if (io.puertas_abiertas && !prev_doors) begin
         stops.push_back(int'(io.piso));
         door_len.push_back(0);
      end
      if (io.puertas_abiertas && door_len.size() > 0)
         door_len[door_len.size()-1] = door_len[door_len.size()-1] + 1;
      if (dirseq.size() == 0 || dirseq[dirseq.size()-1] != int'(io.direccion))
         dirseq.push_back(int'(io.direccion));
      prev_doors = io.puertas_abiertas;
   endtask

   task automatic watch(input int n);
      repeat (n) cycle(4'b0000);
   endtask

   task automatic do_reset();
      io.llamada = 4'b0000;
      rst_n = 1'b0;
      model_reset();
      prev_doors = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_log();
   endtask

   task automatic wait_piso(input logic [1:0] p);
      int n = 0;
      while (io.piso !== p && n < 40) begin
         cycle(4'b0000);
         n++;
      end
      check("wait_piso", io.piso, p);
   endtask

   task automatic wait_doors();
      int n = 0;
      while (io.puertas_abiertas !== 1'b1 && n < 40) begin
         cycle(4'b0000);
         n++;
      end
      check("wait_doors", io.puertas_abiertas, 1'b1);
   endtask

   initial begin
      io.llamada = 4'b0000;
      model_reset();
      prev_doors = 1'b0;

      tbl[0]  = '{4'b1000, 2'd0, 2'b01 & 2'b00, 1'b0, 4'b1000};
      tbl[1]  = '{4'b0000, 2'd0, 2'b01, 1'b0, 4'b1000};
      tbl[2]  = '{4'b0000, 2'd0, 2'b01, 1'b0, 4'b1000};
      tbl[3]  = '{4'b0000, 2'd0, 2'b01, 1'b0, 4'b1000};
      tbl[4]  = '{4'b0000, 2'd0, 2'b01, 1'b0, 4'b1000};
      tbl[5]  = '{4'b0000, 2'd1, 2'b01, 1'b0, 4'b1000};
      tbl[6]  = '{4'b0000, 2'd1, 2'b01, 1'b0, 4'b1000};
      tbl[7]  = '{4'b0000, 2'd1, 2'b01, 1'b0, 4'b1000};
      tbl[8]  = '{4'b0000, 2'd1, 2'b01, 1'b0, 4'b1000};
      tbl[9]  = '{4'b0000, 2'd2, 2'b01, 1'b0, 4'b1000};
      tbl[10] = '{4'b0000, 2'd2, 2'b01, 1'b0, 4'b1000};
      tbl[11] = '{4'b0000, 2'd2, 2'b01, 1'b0, 4'b1000};
      tbl[12] = '{4'b0000, 2'd2, 2'b01, 1'b0, 4'b1000};
      tbl[13] = '{4'b0000, 2'd3, 2'b00, 1'b1, 4'b0000};
      tbl[14] = '{4'b0000, 2'd3, 2'b00, 1'b1, 4'b0000};
      tbl[15] = '{4'b0000, 2'd3, 2'b00, 1'b1, 4'b0000};
      tbl[16] = '{4'b0000, 2'd3, 2'b00, 1'b0, 4'b0000};
      tbl[17] = '{4'b0000, 2'd3, 2'b00, 1'b0, 4'b0000};

      // Reset state and the full trip 0 -> 3 from a single pulse.
      do_reset();
      check("reset_state", dut_vec(), 9'd0);
      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].l);
         check($sformatf("table[%0d]", i), dut_vec(),
               {tbl[i].piso, tbl[i].dir, tbl[i].doors, tbl[i].pend});
      end

      // Asynchronous reset while travelling.
      do_reset();
      cycle(4'b1000);
      wait_piso(2'd1);
      rst_n = 1'b0;
      #1;
      check("async_reset", dut_vec(), 9'd0);
      model_reset();
      prev_doors = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();

      // Call at the current floor.
      do_reset();
      cycle(4'b0001);
      check("cur_floor_e1_doors", io.puertas_abiertas, 1'b0);
      cycle(4'b0000);
      check("cur_floor_e2_doors", io.puertas_abiertas, 1'b1);
      watch(6);
      check("cur_floor_door_len", code(door_len), 32'h3);
      check("cur_floor_piso", io.piso, 2'd0);

      // Pickup of a call raised mid-travel.
      do_reset();
      cycle(4'b1000);
      wait_piso(2'd1);
      clear_log();
      cycle(4'b0100);
      watch(40);
      check("pickup_stops", code(stops), 32'h23);
      check("pickup_door_len", code(door_len), 32'h33);

      // Scan order: serve 3 first, reverse, serve 0.
      do_reset();
      cycle(4'b1000);
      wait_piso(2'd1);
      cycle(4'b0001);
      clear_log();
      watch(50);
      check("scan_stops", code(stops), 32'h30);
      check("scan_dirseq", code(dirseq), 32'h1020);

      // Call for the open-door floor.
      do_reset();
      cycle(4'b0010);
      wait_doors();
      cycle(4'b0010);
      check("door_call_pend1", io.pendientes[1], 1'b0);
      watch(8);
      check("door_call_len", code(door_len), EXTEND ? 32'h4 : 32'h3);

      // Simultaneous calls from floor 1: up first, then down.
      do_reset();
      cycle(4'b0010);
      watch(12);
      check("simul_start", {io.piso, io.direccion, io.puertas_abiertas}, {2'd1, 2'b00, 1'b0});
      clear_log();
      cycle(4'b1001);
      watch(45);
      check("simul_stops", code(stops), 32'h30);

      // Random calls with occasional resets, every cycle compared with the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         cycle(($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
